grayscale_stream_fifo_ise: RTL
==============================

GRAYSCALE_STREAM_FIFO_ISE -- requirements
Module: grayscale_stream_fifo_ise

Interface
REQ-001 The block SHALL take parameter customInstructionId, default 8'd0, as the custom-instruction ID it responds to.
REQ-002 The block SHALL take parameter DEPTH, default 16, as the FIFO depth in 32-bit words; legal values are powers of two from 4 to 256.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: CPU custom-instruction strobe.
REQ-006 The block SHALL have port valueA, input, 32 bits: operand A, four packed 8-bit grayscale pixels, pixel 0 in [7:0].
REQ-007 The block SHALL have port valueB, input, 32 bits: operand B; [1:0] is the opcode and [31:2] is ignored.
REQ-008 The block SHALL have port iseId, input, 8 bits: instruction ID presented with start.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port result, output, 32 bits: instruction result, valid only while done=1.
REQ-011 The block SHALL have port streamData, output, 32 bits: FIFO head word.
REQ-012 The block SHALL have port streamValid, output, 1 bit: the head word is valid.
REQ-013 The block SHALL have port streamReady, input, 1 bit: the downstream consumer accepts the head word.

Function
REQ-014 The block SHALL accept an instruction only when start=1, iseId==customInstructionId and the FSM is in IDLE; a start in any other state SHALL be ignored.
REQ-015 The block SHALL use FSM states IDLE, WAIT_SPACE and DONE; done=1 only in DONE, and DONE SHALL always return to IDLE after one cycle.
REQ-016 Opcodes: 00 PUSH, 01 STATUS, 10 CLEAR, 11 reserved.
REQ-017 PUSH SHALL write valueA at the tail in the accept cycle if there is room, and the FSM SHALL go to DONE, so done rises 1 cycle after start.
REQ-018 "Room" SHALL mean count<DEPTH, or count==DEPTH with a stream handshake (streamValid&streamReady) in the same cycle.
REQ-019 PUSH with no room SHALL register valueA and go to WAIT_SPACE; the word SHALL be written in the first cycle with room, followed by DONE.
REQ-020 PUSH SHALL return result=0.
REQ-021 STATUS SHALL go to DONE with result[31]=full, [30]=empty, [29:16]=0 and [15:0]=count, where count is sampled in the accept cycle.
REQ-022 CLEAR SHALL zero the read pointer, write pointer and count in the accept cycle, go to DONE and return result=0; CLEAR SHALL take priority over a simultaneous stream handshake, so the popped word is discarded.
REQ-023 The reserved opcode SHALL go to DONE with result=0 and no state change.
REQ-024 result SHALL be 32'd0 whenever done=0.
REQ-025 streamValid SHALL be (count!=0); streamData SHALL be the head word, first-word-fall-through, and SHALL be held stable while streamValid=1 and streamReady=0.
REQ-026 A pop SHALL occur on each cycle with streamValid&streamReady; streamReady while empty SHALL have no effect.
REQ-027 A simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-028 count SHALL be log2(DEPTH)+1 bits and never exceed DEPTH.
REQ-029 Words SHALL leave the FIFO in push order with bytes unmodified.

Reset
REQ-030 While reset=0: state=IDLE, pointers=0, count=0, done=0, result=0, streamValid=0 and streamData=0, all asynchronously.
REQ-031 Reset asserted in WAIT_SPACE SHALL abandon the pending push with no done pulse; the FIFO SHALL be empty after release.
REQ-032 Storage contents need no reset; they SHALL be unobservable because streamValid=0.

Verification
REQ-033 Push 0x04030201 with streamReady=0 -> done=1 exactly 1 cycle later with result=0; streamValid=1 and streamData=0x04030201 from the next cycle.
REQ-034 With DEPTH=16 and 16 words pushed, issue a 17th push 0xDEADBEEF with streamReady=0 for 10 cycles, then 1 -> no done during the stall; done the cycle after the first pop; words exit in order, ending with 0xDEADBEEF.
REQ-035 With 3 words queued, STATUS -> result=0x00000003; with an empty FIFO -> 0x40000000; with a full FIFO -> 0x80000010.
REQ-036 With 5 words queued and streamReady=1 in the CLEAR accept cycle -> count=0 next cycle, streamValid=0, done=1 with result=0.
REQ-037 Issue start with iseId≠customInstructionId, or start during DONE/WAIT_SPACE -> no done, result=0, FIFO unchanged.
REQ-038 Run 1000 random pushes against random streamReady -> output sequence equals push sequence, count never exceeds 16, and result=0 whenever done=0.

Source files
------------

// File: rtl/grayscale_stream_fifo_ise.sv
// rtl/grayscale_stream_fifo_ise.sv - custom-instruction front end pushing packed grayscale words into a FWFT stream FIFO
module grayscale_stream_fifo_ise #(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         DEPTH               = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  iseId,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] streamData,
  output logic        streamValid,
  input  logic        streamReady
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] OP_PUSH   = 2'b00;
  localparam logic [1:0] OP_STATUS = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pend_q, pend_d;
  logic            done_q, done_d;
  logic [31:0]     result_q, result_d;
  logic [31:0]     mem_q [DEPTH];

  logic            pop, full, empty, room, accept, push, clear;
  logic [31:0]     push_data;
  logic            unused_opcode_bits;

  assign unused_opcode_bits = ^valueB[31:2];

  always_comb begin
    pop       = (count_q != '0) && streamReady;
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    // A full FIFO still has room when the head leaves on the same edge.
    room      = !full || pop;
    accept    = start && (iseId == customInstructionId) && (state_q == IDLE);
    state_d   = state_q;
    pend_d    = pend_q;
    result_d  = '0;
    push      = 1'b0;
    push_data = valueA;
    clear     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (valueB[1:0])
            OP_PUSH: begin
              if (room) begin
                push    = 1'b1;
                state_d = DONE;
              end else begin
                pend_d  = valueA;
                state_d = WAIT_SPACE;
              end
            end
            OP_STATUS: begin
              result_d = {full, empty, 14'd0, 16'(count_q)};
              state_d  = DONE;
            end
            OP_CLEAR: begin
              clear   = 1'b1;
              state_d = DONE;
            end
            default: state_d = DONE;
          endcase
        end
      end
      WAIT_SPACE: begin
        if (room) begin
          push      = 1'b1;
          push_data = pend_q;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);

    // CLEAR wins over a same-cycle pop, discarding the head word.
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign done        = done_q;
  assign result      = result_q;
  assign streamValid = (count_q != '0);
  assign streamData  = streamValid ? mem_q[rd_ptr_q] : '0;

endmodule
